// File: rtl/v810_sysreg_exc.sv
`default_nettype none
// ============================================================================
//  Module      : v810_sysreg_exc
//  Description : V810 system-register bank (EIPC/EIPSW/FEPC/FEPSW/ECR/PSW/
//                ADTRE, read-only PIR/TKCW, external CHCW) with a small FSM
//                sequencing normal, duplexed and fatal exception entry and
//                RETI restore.
//  Revision    : 1.0  initial release
// ============================================================================
// PSW layout: [3:0] Z/S/OV/CY, [9:4] FPR/FUD/FOV/FZD/FIV/FRO, [12] ID,
//             [13] AE, [14] EP, [15] NP, [19:16] I, all other bits read 0.
module v810_sysreg_exc #(
   parameter logic [31:0] PIR_VAL    = 32'h0000_5346,
   parameter logic [31:0] TKCW_VAL   = 32'h0000_00E0,
   parameter logic [31:0] PSW_RST    = 32'h0000_8000,
   parameter logic [31:0] ECR_RST    = 32'h0000_FFF0,
   parameter int          HAS_ADTRE  = 1,
   parameter int          INT_LEVELS = 16,
   localparam int         LVL_W      = (INT_LEVELS > 1) ? $clog2(INT_LEVELS) : 1
) (
   input  logic              CLK,
   input  logic              RESn,
   input  logic              CE,
   input  logic [4:0]        RA,
   output logic [31:0]       RD,
   input  logic [4:0]        WA,
   input  logic [31:0]       WD,
   input  logic              WE,
   output logic [31:0]       PSW,
   input  logic              EXC_REQ,
   input  logic [15:0]       EXC_CODE,
   input  logic [31:0]       EXC_PC,
   input  logic              EXC_IS_INT,
   input  logic [LVL_W-1:0]  EXC_LEVEL,
   output logic              EXC_ACK,
   output logic [1:0]        EXC_KIND,
   input  logic              RETI_REQ,
   output logic              RETI_ACK,
   output logic [31:0]       RETI_PC,
   output logic              HALTED,
   input  logic [31:0]       CHCW,
   output logic [31:0]       CHCW_WD,
   output logic              CHCW_WE
);

   // System-register selectors
   localparam logic [4:0] c_SRSEL_EIPC  = 5'd0;
   localparam logic [4:0] c_SRSEL_EIPSW = 5'd1;
   localparam logic [4:0] c_SRSEL_FEPC  = 5'd2;
   localparam logic [4:0] c_SRSEL_FEPSW = 5'd3;
   localparam logic [4:0] c_SRSEL_ECR   = 5'd4;
   localparam logic [4:0] c_SRSEL_PSW   = 5'd5;
   localparam logic [4:0] c_SRSEL_PIR   = 5'd6;
   localparam logic [4:0] c_SRSEL_TKCW  = 5'd7;
   localparam logic [4:0] c_SRSEL_CHCW  = 5'd24;
   localparam logic [4:0] c_SRSEL_ADTRE = 5'd25;

   // Implemented-bit masks
   localparam logic [31:0] c_PSW_MASK = 32'h000F_F3FF;
   localparam logic [31:0] c_PC_MASK  = 32'hFFFF_FFFE;

   // PSW bit positions
   localparam int c_ID = 12;
   localparam int c_AE = 13;
   localparam int c_EP = 14;
   localparam int c_NP = 15;

   // Entry kinds
   localparam logic [1:0] c_KIND_NORMAL = 2'd0;
   localparam logic [1:0] c_KIND_DUP    = 2'd1;
   localparam logic [1:0] c_KIND_FATAL  = 2'd2;

   // Highest reachable interrupt mask level (PSW.I is 4 bits wide)
   localparam logic [4:0] c_I_MAX = (INT_LEVELS > 16) ? 5'd15 : 5'(INT_LEVELS - 1);

   // FSM states
   localparam logic [2:0] c_ST_IDLE    = 3'd0;
   localparam logic [2:0] c_ST_SAVE    = 3'd1;
   localparam logic [2:0] c_ST_COMMIT  = 3'd2;
   localparam logic [2:0] c_ST_RESTORE = 3'd3;
   localparam logic [2:0] c_ST_HALT    = 3'd4;

   logic [2:0]        r_state;
   logic [31:0]       r_eipc;
   logic [31:0]       r_eipsw;
   logic [31:0]       r_fepc;
   logic [31:0]       r_fepsw;
   logic [31:0]       r_ecr;
   logic [31:0]       r_psw;
   logic [1:0]        r_kind;
   logic              r_is_int;
   logic [LVL_W-1:0]  r_level;
   logic              r_halt_acked;
   logic [31:0]       r_reti_pc;
   logic              r_reti_fe;
   logic [31:0]       w_adtre;

   logic              w_halt;
   logic              w_ldsr;
   logic [1:0]        w_save_kind;
   logic              w_save_norm;
   logic              w_save_dup;
   logic [4:0]        w_lvl_inc;
   logic [3:0]        w_new_i;
   logic [31:0]       w_psw_commit;

   assign w_halt      = (r_state == c_ST_HALT);
   // LDSR is live whenever the block is clocked and not halted
   assign w_ldsr      = CE & WE & ~w_halt;
   assign w_save_kind = r_psw[c_NP] ? c_KIND_FATAL :
                        r_psw[c_EP] ? c_KIND_DUP   : c_KIND_NORMAL;
   assign w_save_norm = (r_state == c_ST_SAVE) && (w_save_kind == c_KIND_NORMAL);
   assign w_save_dup  = (r_state == c_ST_SAVE) && (w_save_kind == c_KIND_DUP);

   // New mask level: one above the accepted interrupt, saturating at the top level
   assign w_lvl_inc = 5'(r_level) + 5'd1;
   assign w_new_i   = (w_lvl_inc > c_I_MAX) ? c_I_MAX[3:0] : w_lvl_inc[3:0];

   // PSW value written when an exception entry commits
   always_comb begin
      w_psw_commit = r_psw;
      if (r_kind == c_KIND_DUP) begin
         w_psw_commit[c_NP] = 1'b1;
      end else begin
         w_psw_commit[c_EP] = 1'b1;
      end
      w_psw_commit[c_ID] = 1'b1;
      w_psw_commit[c_AE] = 1'b0;
      if (r_is_int) begin
         w_psw_commit[19:16] = w_new_i;
      end
   end

   // Sequencer: entry/return FSM plus the values latched for later steps
   always_ff @(posedge CLK or negedge RESn) begin
      if (!RESn) begin
         r_state      <= c_ST_IDLE;
         r_kind       <= c_KIND_NORMAL;
         r_is_int     <= 1'b0;
         r_level      <= '0;
         r_halt_acked <= 1'b0;
         r_reti_pc    <= 32'h0;
         r_reti_fe    <= 1'b0;
      end else if (CE) begin
         case (r_state)
            c_ST_IDLE: begin
               if (EXC_REQ) begin
                  r_state <= c_ST_SAVE;
               end else if (RETI_REQ) begin
                  r_state   <= c_ST_RESTORE;
                  r_reti_fe <= r_psw[c_NP];
                  r_reti_pc <= r_psw[c_NP] ? r_fepc : r_eipc;
               end
            end
            c_ST_SAVE: begin
               r_kind   <= w_save_kind;
               r_is_int <= EXC_IS_INT;
               r_level  <= EXC_LEVEL;
               r_state  <= (w_save_kind == c_KIND_FATAL) ? c_ST_HALT : c_ST_COMMIT;
            end
            c_ST_COMMIT:  r_state <= c_ST_IDLE;
            c_ST_RESTORE: r_state <= c_ST_IDLE;
            c_ST_HALT:    r_halt_acked <= 1'b1;
            default:      r_state <= c_ST_IDLE;
         endcase
      end
   end

   // Exception save registers; an FSM save beats a same-cycle LDSR
   always_ff @(posedge CLK or negedge RESn) begin
      if (!RESn) begin
         r_eipc  <= 32'h0;
         r_eipsw <= 32'h0;
         r_fepc  <= 32'h0;
         r_fepsw <= 32'h0;
         r_ecr   <= ECR_RST;
      end else if (CE) begin
         if (w_save_norm) begin
            r_eipc  <= EXC_PC & c_PC_MASK;
            r_eipsw <= r_psw;
         end else begin
            if (w_ldsr && WA == c_SRSEL_EIPC)  r_eipc  <= WD & c_PC_MASK;
            if (w_ldsr && WA == c_SRSEL_EIPSW) r_eipsw <= WD & c_PSW_MASK;
         end
         if (w_save_dup) begin
            r_fepc  <= EXC_PC & c_PC_MASK;
            r_fepsw <= r_psw;
         end else begin
            if (w_ldsr && WA == c_SRSEL_FEPC)  r_fepc  <= WD & c_PC_MASK;
            if (w_ldsr && WA == c_SRSEL_FEPSW) r_fepsw <= WD & c_PSW_MASK;
         end
         if (w_save_norm) begin
            r_ecr[15:0] <= EXC_CODE;
         end else if (w_save_dup) begin
            r_ecr[31:16] <= EXC_CODE;
         end else if (w_ldsr && WA == c_SRSEL_ECR) begin
            r_ecr <= WD;
         end
      end
   end

   // PSW: entry commit and RETI restore take priority over LDSR
   always_ff @(posedge CLK or negedge RESn) begin
      if (!RESn) begin
         r_psw <= PSW_RST & c_PSW_MASK;
      end else if (CE) begin
         if (r_state == c_ST_COMMIT) begin
            r_psw <= w_psw_commit;
         end else if (r_state == c_ST_RESTORE) begin
            r_psw <= r_reti_fe ? r_fepsw : r_eipsw;
         end else if (w_ldsr && WA == c_SRSEL_PSW) begin
            r_psw <= WD & c_PSW_MASK;
         end
      end
   end

   generate
      if (HAS_ADTRE != 0) begin : g_adtre
         logic [31:0] r_adtre;
         // Address-trap register, LDSR-only
         always_ff @(posedge CLK or negedge RESn) begin
            if (!RESn) begin
               r_adtre <= 32'h0;
            end else if (w_ldsr && WA == c_SRSEL_ADTRE) begin
               r_adtre <= WD & c_PC_MASK;
            end
         end
         assign w_adtre = r_adtre;
      end else begin : g_no_adtre
         assign w_adtre = 32'h0;
      end
   endgenerate

   // STSR read mux: register state at cycle start, no bypass of pending writes
   always_comb begin
      RD = 32'h0;
      case (RA)
         c_SRSEL_EIPC:  RD = r_eipc;
         c_SRSEL_EIPSW: RD = r_eipsw;
         c_SRSEL_FEPC:  RD = r_fepc;
         c_SRSEL_FEPSW: RD = r_fepsw;
         c_SRSEL_ECR:   RD = r_ecr;
         c_SRSEL_PSW:   RD = r_psw;
         c_SRSEL_PIR:   RD = PIR_VAL;
         c_SRSEL_TKCW:  RD = TKCW_VAL;
         c_SRSEL_CHCW:  RD = CHCW;
         c_SRSEL_ADTRE: RD = w_adtre;
         default:       RD = 32'h0;
      endcase
   end

   assign PSW      = r_psw;
   assign EXC_ACK  = (r_state == c_ST_COMMIT) | (w_halt & ~r_halt_acked);
   assign EXC_KIND = r_kind;
   assign RETI_ACK = (r_state == c_ST_RESTORE);
   assign RETI_PC  = r_reti_pc;
   assign HALTED   = w_halt;
   assign CHCW_WD  = WD;
   assign CHCW_WE  = w_ldsr & (WA == c_SRSEL_CHCW);

endmodule
`default_nettype wire
